// File: rtl/sbox_share_arbiter.sv
// sbox_share_arbiter: time-shares four combinational AES S-box lanes between
// the round datapath (SubBytes on a 128-bit state, four 32-bit passes) and
// the key scheduler (SubWord on a 32-bit word, one pass), with round-robin
// arbitration and valid/ready handshakes on every port.

// Single AES S-box lane: pure table lookup, combinational.
module sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    // Entry for input x lives at bits [(255-x)*8 +: 8]; row 0 is the MSB end.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // ~x equals 255-x, so {~x, 3'b000} is the bit offset of entry x.
    assign o_byte = SBOX_TBL[{~i_byte, 3'b000} +: 8];
endmodule

module sbox_share_arbiter #(
    parameter bit KEY_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_in_valid,
    output logic         st_in_ready,
    input  logic [127:0] st_in_data,
    output logic         st_out_valid,
    input  logic         st_out_ready,
    output logic [127:0] st_out_data,
    input  logic         key_in_valid,
    output logic         key_in_ready,
    input  logic [31:0]  key_in_data,
    output logic         key_out_valid,
    input  logic         key_out_ready,
    output logic [31:0]  key_out_data,
    output logic         busy
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ST_RUN   = 3'd1,
        KEY_RUN  = 3'd2,
        ST_DONE  = 3'd3,
        KEY_DONE = 3'd4
    } state_t;

    localparam logic GRANT_STATE = 1'b0;
    localparam logic GRANT_KEY   = 1'b1;

    state_t       r_state;
    state_t       w_next_state;
    logic [1:0]   r_cnt;
    logic [1:0]   w_next_cnt;
    logic         r_last_grant;
    logic         w_next_last_grant;
    // Low during reset and the cycle after it, so no ready appears then.
    logic         r_rst_done;
    logic [127:0] r_in_buf;
    logic [127:0] r_out_buf;

    logic         w_idle;
    logic         w_st_acc;
    logic         w_key_acc;
    logic         w_run;
    logic [31:0]  w_lane_in;
    logic [31:0]  w_lane_out;

    // Readies depend only on registered state and the opposing valid.
    assign w_idle       = (r_state == IDLE) && r_rst_done;
    assign key_in_ready = w_idle && (!st_in_valid  || (r_last_grant == GRANT_STATE));
    assign st_in_ready  = w_idle && (!key_in_valid || (r_last_grant == GRANT_KEY));

    assign w_st_acc  = st_in_valid  && st_in_ready;
    assign w_key_acc = key_in_valid && key_in_ready;
    assign w_run     = (r_state == ST_RUN) || (r_state == KEY_RUN);

    assign st_out_valid  = (r_state == ST_DONE);
    assign key_out_valid = (r_state == KEY_DONE);
    assign busy          = (r_state != IDLE);
    assign st_out_data   = r_out_buf;
    assign key_out_data  = r_out_buf[31:0];

    // Next-state, chunk counter and grant-history logic.
    always_comb begin
        w_next_state      = r_state;
        w_next_cnt        = r_cnt;
        w_next_last_grant = r_last_grant;
        case (r_state)
            IDLE: begin
                if (w_st_acc) begin
                    w_next_state      = ST_RUN;
                    w_next_cnt        = 2'd0;
                    w_next_last_grant = GRANT_STATE;
                end else if (w_key_acc) begin
                    w_next_state      = KEY_RUN;
                    w_next_cnt        = 2'd0;
                    w_next_last_grant = GRANT_KEY;
                end
            end
            ST_RUN: begin
                w_next_cnt = r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    w_next_state = ST_DONE;
                end
            end
            KEY_RUN: begin
                w_next_state = KEY_DONE;
            end
            ST_DONE: begin
                if (st_out_ready) begin
                    w_next_state = IDLE;
                end
            end
            KEY_DONE: begin
                if (key_out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Control state register; reset discards any in-flight job.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= 2'd0;
            r_last_grant <= KEY_FIRST ? GRANT_STATE : GRANT_KEY;
            r_rst_done   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_next_cnt;
            r_last_grant <= w_next_last_grant;
            r_rst_done   <= 1'b1;
        end
    end

    // Select the 32-bit chunk feeding the lanes; a key job runs with c=0.
    always_comb begin
        w_lane_in = r_in_buf[31:0];
        case (r_cnt)
            2'd0: w_lane_in = r_in_buf[31:0];
            2'd1: w_lane_in = r_in_buf[63:32];
            2'd2: w_lane_in = r_in_buf[95:64];
            2'd3: w_lane_in = r_in_buf[127:96];
            default: w_lane_in = r_in_buf[31:0];
        endcase
    end

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_lane
            sbox u_sbox (
                .i_byte (w_lane_in[8*g +: 8]),
                .o_byte (w_lane_out[8*g +: 8])
            );
        end
    endgenerate

    // Input capture and per-pass result write-back into the output buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_buf  <= '0;
            r_out_buf <= '0;
        end else begin
            if (w_st_acc) begin
                r_in_buf <= st_in_data;
            end else if (w_key_acc) begin
                r_in_buf[31:0] <= key_in_data;
            end
            if (w_run) begin
                case (r_cnt)
                    2'd0: r_out_buf[31:0]   <= w_lane_out;
                    2'd1: r_out_buf[63:32]  <= w_lane_out;
                    2'd2: r_out_buf[95:64]  <= w_lane_out;
                    2'd3: r_out_buf[127:96] <= w_lane_out;
                    default: r_out_buf[31:0] <= w_lane_out;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sbox_share_arbiter.sv
// Scoreboard bench for sbox_share_arbiter: accepted jobs push an expected
// result computed from GF(2^8) arithmetic; output monitors pop and compare.
`timescale 1ns/1ps
module tb_sbox_share_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         st_in_valid = 1'b0;
    logic         st_in_ready;
    logic [127:0] st_in_data = '0;
    logic         st_out_valid;
    logic         st_out_ready = 1'b0;
    logic [127:0] st_out_data;
    logic         key_in_valid = 1'b0;
    logic         key_in_ready;
    logic [31:0]  key_in_data = '0;
    logic         key_out_valid;
    logic         key_out_ready = 1'b0;
    logic [31:0]  key_out_data;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int st_skip = 0;
    int key_skip = 0;
    int drv_done = 0;

    logic [127:0] exp_st[$];
    logic [31:0]  exp_key[$];
    bit           grants[$];

    sbox_share_arbiter #(.KEY_FIRST(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .st_in_valid   (st_in_valid),
        .st_in_ready   (st_in_ready),
        .st_in_data    (st_in_data),
        .st_out_valid  (st_out_valid),
        .st_out_ready  (st_out_ready),
        .st_out_data   (st_out_data),
        .key_in_valid  (key_in_valid),
        .key_in_ready  (key_in_ready),
        .key_in_data   (key_in_data),
        .key_out_valid (key_out_valid),
        .key_out_ready (key_out_ready),
        .key_out_data  (key_out_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // AES S-box from the field inverse (a^254) followed by the affine map.
    function automatic logic [7:0] sb(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = a;
        e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub128(input logic [127:0] d);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sb(d[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [31:0] sub32(input logic [31:0] d);
        logic [31:0] o;
        for (int i = 0; i < 4; i++) o[8*i +: 8] = sb(d[8*i +: 8]);
        return o;
    endfunction

    // Input monitor: push expectations on accept, record grants and fairness.
    always @(negedge clk) begin
        if (!rst) begin
            if (st_in_valid && st_in_ready) begin
                exp_st.push_back(sub128(st_in_data));
                grants.push_back(1'b0);
                if (key_in_valid) key_skip++;
                st_skip = 0;
                check("fair_key_wait", key_skip <= 1, 1);
            end
            if (key_in_valid && key_in_ready) begin
                exp_key.push_back(sub32(key_in_data));
                grants.push_back(1'b1);
                if (st_in_valid) st_skip++;
                key_skip = 0;
                check("fair_st_wait", st_skip <= 1, 1);
            end
        end
    end

    // Output monitor: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (st_out_valid && st_out_ready) begin
                if (exp_st.size() == 0) check("st_unexpected_out", st_out_data, 'x);
                else check("st_out_data", st_out_data, exp_st.pop_front());
            end
            if (key_out_valid && key_out_ready) begin
                if (exp_key.size() == 0) check("key_unexpected_out", key_out_data, 'x);
                else check("key_out_data", key_out_data, exp_key.pop_front());
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset(input string tag);
        @(posedge clk); #1;
        rst = 1'b1; st_in_valid = 1'b0; key_in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check({tag, "_st_in_ready"}, st_in_ready, 0);
        check({tag, "_key_in_ready"}, key_in_ready, 0);
        check({tag, "_st_out_valid"}, st_out_valid, 0);
        check({tag, "_key_out_valid"}, key_out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_st_out_data"}, st_out_data, 0);
        check({tag, "_key_out_data"}, key_out_data, 0);
        exp_st.delete(); exp_key.delete(); grants.delete();
        st_skip = 0; key_skip = 0;
    endtask

    task automatic wait_accept(input bit is_key);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (is_key ? (key_in_valid && key_in_ready) : (st_in_valid && st_in_ready)) got = 1'b1;
        end
        if (!got) check(is_key ? "key_accept_timeout" : "st_accept_timeout", 0, 1);
        @(posedge clk); #1;
        if (is_key) key_in_valid = 1'b0; else st_in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (!busy) got = 1'b1;
        end
        if (!got) check({tag, "_idle_timeout"}, busy, 0);
    endtask

    task automatic job_watch(input bit is_key, input int win, output int lat, output int vcnt,
                             output int bcnt, output logic [127:0] dat);
        lat = -1; vcnt = 0; bcnt = 0; dat = '0;
        for (int i = 1; i <= win; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (is_key ? key_out_valid : st_out_valid) begin
                if (vcnt == 0) begin
                    lat = i;
                    dat = is_key ? {96'b0, key_out_data} : st_out_data;
                end
                vcnt++;
            end
        end
    endtask

    logic [31:0]  key_vec [2] = '{32'h00010253, 32'hffffffff};
    logic [31:0]  key_exp [2] = '{32'h637c77ed, 32'h16161616};

    initial begin
        int lat, vcnt, bcnt;
        logic [127:0] dat;
        bit got;

        // Reset state
        apply_reset("rst0");

        // Single state job, always-ready consumer
        @(posedge clk); #1;
        st_out_ready = 1'b1; key_out_ready = 1'b1;
        st_in_data = 128'h000102030405060708090a0b0c0d0e0f;
        st_in_valid = 1'b1;
        wait_accept(1'b0);
        job_watch(1'b0, 10, lat, vcnt, bcnt, dat);
        check("st_latency", lat, 5);
        check("st_valid_width", vcnt, 1);
        check("st_busy_cycles", bcnt, 5);
        check("st_vector", dat, 128'h637c777bf26b6fc53001672bfed7ab76);

        // Key jobs
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            key_in_data = key_vec[k];
            key_in_valid = 1'b1;
            wait_accept(1'b1);
            job_watch(1'b1, 6, lat, vcnt, bcnt, dat);
            check("key_latency", lat, 2);
            check("key_valid_width", vcnt, 1);
            check("key_busy_cycles", bcnt, 2);
            check("key_vector", dat, {96'b0, key_exp[k]});
        end

        // Both requesters valid every cycle: grants must alternate, key first
        apply_reset("rst1");
        @(posedge clk); #1;
        st_in_data = 128'h00112233445566778899aabbccddeeff;
        key_in_data = 32'hdeadbeef;
        st_in_valid = 1'b1; key_in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("both_ready", st_in_ready && key_in_ready, 0);
            got = (st_in_valid && st_in_ready) || (key_in_valid && key_in_ready);
            @(posedge clk); #1;
            if (got) begin
                st_in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
                key_in_data = $urandom();
            end
        end
        st_in_valid = 1'b0; key_in_valid = 1'b0;
        wait_idle("rr");
        check("rr_grant_count_ok", grants.size() >= 4, 1);
        for (int k = 0; k < 4; k++) begin
            if (k < grants.size()) check($sformatf("rr_grant%0d", k), grants[k], (k % 2) == 0);
        end

        // Output backpressure on the state result while a key waits
        @(posedge clk); #1;
        st_out_ready = 1'b0;
        st_in_data = {16{8'h53}};
        st_in_valid = 1'b1;
        wait_accept(1'b0);
        key_in_data = 32'h01020304;
        key_in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (st_out_valid) got = 1'b1;
        end
        check("bp_valid_seen", got, 1);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            check("bp_valid_held", st_out_valid, 1);
            check("bp_data_stable", st_out_data, {16{8'hed}});
            check("bp_key_ready_low", key_in_ready, 0);
        end
        @(posedge clk); #1;
        st_out_ready = 1'b1;
        @(negedge clk);
        check("bp_key_ready_at_handshake", key_in_ready, 0);
        @(negedge clk);
        check("bp_key_ready_after", key_in_ready, 1);
        @(posedge clk); #1;
        key_in_valid = 1'b0;
        wait_idle("bp");

        // Reset in the middle of a state job (c==2)
        @(posedge clk); #1;
        st_in_data = 128'h000102030405060708090a0b0c0d0e0f;
        st_in_valid = 1'b1;
        wait_accept(1'b0);
        @(posedge clk); #1;
        apply_reset("rst_mid");
        job_watch(1'b0, 12, lat, vcnt, bcnt, dat);
        check("mid_no_valid", vcnt, 0);
        check("mid_no_busy", bcnt, 0);
        @(posedge clk); #1;
        st_in_data = '0;
        st_in_valid = 1'b1;
        wait_accept(1'b0);
        job_watch(1'b0, 10, lat, vcnt, bcnt, dat);
        check("zero_latency", lat, 5);
        check("zero_vector", dat, {16{8'h63}});

        // Random mix: 500 jobs per requester with random valid/ready timing
        fork
            begin
                for (int n = 0; n < 500; n++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    st_in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
                    st_in_valid = 1'b1;
                    wait_accept(1'b0);
                end
                drv_done++;
            end
            begin
                for (int n = 0; n < 500; n++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    key_in_data = $urandom();
                    key_in_valid = 1'b1;
                    wait_accept(1'b1);
                end
                drv_done++;
            end
            begin
                while (drv_done < 2) begin
                    @(posedge clk); #1;
                    st_out_ready = ($urandom_range(0, 3) != 0);
                    key_out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        @(posedge clk); #1;
        st_out_ready = 1'b1; key_out_ready = 1'b1;
        wait_idle("rand");
        repeat (2) @(negedge clk);
        check("st_queue_drained", exp_st.size(), 0);
        check("key_queue_drained", exp_key.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sbox_share_arbiter.md
# sbox_share_arbiter

Time-shares one bank of four S-box lanes between the AES round datapath (SubBytes on a 128-bit state) and the key-expansion unit (SubWord on a 32-bit word). A state job takes four passes of 4 bytes each; a key job takes one pass. Both requesters use valid/ready handshakes on input and output. Arbitration is round-robin. The block sits between the round controller, the key scheduler and four internally instantiated `sbox` lanes.

## Interface
- `KEY_FIRST`, default 1: winner of the first tie after reset. 1 = key requester, 0 = state requester.
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `st_in_valid`  in  1  state job offered
- `st_in_ready`  out  1  state job accepted this cycle when both valid and ready are high
- `st_in_data`  in  128  state; byte i = bits [8i+7:8i]
- `st_out_valid`  out  1  SubBytes result available
- `st_out_ready`  in  1  result consumer ready
- `st_out_data`  out  128  byte i = S(st_in_data byte i)
- `key_in_valid`  in  1  word offered
- `key_in_ready`  out  1  word accepted
- `key_in_data`  in  32  word; byte order as above
- `key_out_valid`  out  1  SubWord result available
- `key_out_ready`  in  1  result consumer ready
- `key_out_data`  out  32  byte i = S(key_in_data byte i)
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states:
  - IDLE: no job held.
  - ST_RUN: 2-bit chunk counter `c`, values 0..3.
  - KEY_RUN: one-cycle S-box pass on the key word.
  - ST_DONE: state result held for the consumer.
  - KEY_DONE: key result held for the consumer.
- Ready generation. `last_grant` is a one-bit register recording which requester was last accepted.
  - `key_in_ready = IDLE & (!st_in_valid | last_grant==STATE)`
  - `st_in_ready = IDLE & (!key_in_valid | last_grant==KEY)`
  - Ready signals are only ever high in IDLE. At most one ready is high per cycle.
- Reset value of `last_grant`: STATE when KEY_FIRST=1, KEY when KEY_FIRST=0.
- State accept:
  - Capture `st_in_data` into the input buffer.
  - Set `c=0`, enter ST_RUN, set `last_grant=STATE`.
- ST_RUN:
  - Lanes 0..3 are driven with buffer bytes 4c..4c+3.
  - Lane results are registered into output buffer bytes 4c..4c+3.
  - Increment `c` each cycle. When `c==3`, go to ST_DONE.
- Key accept:
  - Capture `key_in_data`, enter KEY_RUN, set `last_grant=KEY`.
- KEY_RUN:
  - Lanes are driven with the key word.
  - Results are registered into output buffer bytes 0..3.
  - Go to KEY_DONE.
- DONE states:
  - The corresponding `*_out_valid` is high and `*_out_data` is stable.
  - On an output handshake, return to IDLE.
  - The output buffer may retain stale data after the handshake; `*_out_data` is don't-care while its valid is low.
- There is no bypass: a new job can only be accepted on the cycle after the output handshake.
- No preemption: a job in progress always completes before the other requester is served.
- Reset, including mid-job:
  - State goes to IDLE; `c=0`.
  - All valid/ready outputs go to 0 in the cycle after reset is sampled; `busy=0`.
  - Data buffers go to 0. Any in-flight job is discarded.
- Reset values of every output: `st_in_ready`, `key_in_ready`, `st_out_valid`, `key_out_valid` and `busy` are 0. `st_out_data` and `key_out_data` are 0.

## Timing
- All registers update on the `clk` rising edge.
- The S-box lanes are combinational; their results are registered in this block.
- State job:
  - Accept edge at cycle T.
  - ST_RUN during cycles T+1..T+4.
  - `st_out_valid` high from cycle T+5.
  - Latency: 5 cycles from accept to valid.
- Key job:
  - Accept edge at T, KEY_RUN at T+1, `key_out_valid` high from T+2.
  - Latency: 2 cycles.
- Output handshake at cycle U: IDLE at U+1, next accept possible at U+1.
- Back-to-back throughput with an always-ready consumer:
  - State: one job per 6 cycles.
  - Key: one job per 3 cycles.
- Ready signals depend combinationally on the opposing valid and on registered state only. There is no path from output ready to input ready.

## Test plan
- Reset then a state job with `st_in_data=128'h000102030405060708090a0b0c0d0e0f` and `st_out_ready=1`:
  - `st_out_valid` rises exactly 5 cycles after accept.
  - `st_out_data=128'h637c777bf26b6fc53001672bfed7ab76`.
  - Pulse is 1 cycle wide; `busy` is high for 5 cycles.
- Key job with `key_in_data=32'h00010253`:
  - `key_out_data=32'h637c77ed`, valid 2 cycles after accept.
  - Also check all-ones input: `32'hffffffff` -> `32'h16161616`.
- Both valid every cycle from IDLE, KEY_FIRST=1, consumers always ready:
  - Grants alternate key, state, key, state.
  - The first grant is key.
  - Never both ready in one cycle.
- Output backpressure: hold `st_out_ready=0` for 10 cycles after `st_out_valid` rises.
  - Data stays stable and valid stays high.
  - `key_in_ready` stays 0 although `key_in_valid=1`.
  - Key is accepted the cycle after `st_out_ready` is raised.
- Assert `rst` for 1 cycle at `c==2` of a state job:
  - All outputs are 0 the next cycle; no `st_out_valid` ever appears.
  - A fresh all-zero state job then returns `128'h6363...63` (16 bytes of 0x63).
- Random mix of 1000 jobs with random valid/ready from both requesters, checked against a scoreboard using the AES S-box:
  - Data correct for every job.
  - Wait between arbitration wins bounded at one opposing job.
